// File: rtl/tnkiii_vram_arbiter.sv
// tnkiii_vram_arbiter
// Shares the video RAM bus among video fetch and two CPUs, one slot at a time.
// A slot is the interval between two clk edges with cen=1 ("slot edges").
// Video has absolute priority. The two CPUs are served round robin. A CPU
// access takes exactly one slot and completes, with an ack pulse, at the
// slot edge that ends it.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   cen                 slot strobe (clock enable for arbitration)
//   vid_slot            video owns the bus in the coming slot
//   a_*/b_*             CPU A / CPU B request: req, we, addr, wdata in;
//                       ack, rdata, wait, starve out
//   vd_in               read data from the shared VRAMs
//   ae, be              CPU A / CPU B owns the bus
//   v_c                 1 = video drives the SRAM address mux
//   va, vd_out, voe, vwe shared bus address, write data, output/write enable
module tnkiii_vram_arbiter #(
  parameter int AW       = 13,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cen,
  input  logic          vid_slot,
  input  logic          a_req,
  input  logic          b_req,
  input  logic          a_we,
  input  logic          b_we,
  input  logic [AW-1:0] a_addr,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic [DW-1:0] b_wdata,
  input  logic [DW-1:0] vd_in,
  output logic          a_ack,
  output logic          b_ack,
  output logic [DW-1:0] a_rdata,
  output logic [DW-1:0] b_rdata,
  output logic          a_wait,
  output logic          b_wait,
  output logic          ae,
  output logic          be,
  output logic          v_c,
  output logic [AW-1:0] va,
  output logic [DW-1:0] vd_out,
  output logic          voe,
  output logic          vwe,
  output logic          a_starve,
  output logic          b_starve
);

  typedef enum logic [1:0] {IDLE, VIDEO, CPU_ACC} state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_t state, state_nxt;

  logic          gnt_b_q;   // side owning the current access (1 = B)
  logic          last_b;    // side granted most recently (1 = B)
  logic          we_q;
  logic [3:0]    a_cnt, b_cnt;
  logic [3:0]    a_cnt_nxt, b_cnt_nxt;

  logic          done_a, done_b;
  logic          a_elig, b_elig;
  logic          pick_b, grant, grant_a, grant_b;
  logic          we_sel;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;

  assign a_wait = a_req & ~a_ack;
  assign b_wait = b_req & ~b_ack;

  always_comb begin
    state_nxt = state;
    a_cnt_nxt = a_cnt;
    b_cnt_nxt = b_cnt;

    // The access in flight completes at this slot edge.
    done_a = cen && (state == CPU_ACC) && !gnt_b_q;
    done_b = cen && (state == CPU_ACC) &&  gnt_b_q;

    // A side being acked still holds req this edge; it must not be re-served.
    a_elig = a_req && !done_a;
    b_elig = b_req && !done_b;

    // On a tie, the side that was not granted last wins.
    pick_b  = b_elig && (!a_elig || !last_b);
    grant   = cen && !vid_slot && (a_elig || b_elig);
    grant_a = grant && !pick_b;
    grant_b = grant &&  pick_b;

    we_sel    = pick_b ? b_we    : a_we;
    addr_sel  = pick_b ? b_addr  : a_addr;
    wdata_sel = pick_b ? b_wdata : a_wdata;

    if (cen) begin
      if (vid_slot)
        state_nxt = VIDEO;
      else if (a_elig || b_elig)
        state_nxt = CPU_ACC;
      else
        state_nxt = IDLE;

      // Counters clear on grant or on a dropped request; the completing edge
      // of a side's own access neither counts as waiting nor clears.
      if (!a_req || grant_a)      a_cnt_nxt = 4'd0;
      else if (done_a)            a_cnt_nxt = a_cnt;
      else if (a_cnt != 4'hF)     a_cnt_nxt = a_cnt + 4'd1;

      if (!b_req || grant_b)      b_cnt_nxt = 4'd0;
      else if (done_b)            b_cnt_nxt = b_cnt;
      else if (b_cnt != 4'hF)     b_cnt_nxt = b_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ae       <= 1'b0;
      be       <= 1'b0;
      v_c      <= 1'b1;
      voe      <= 1'b0;
      vwe      <= 1'b0;
      va       <= '0;
      vd_out   <= '1;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_rdata  <= '1;
      b_rdata  <= '1;
      a_cnt    <= 4'd0;
      b_cnt    <= 4'd0;
      a_starve <= 1'b0;
      b_starve <= 1'b0;
      last_b   <= 1'b1;
      gnt_b_q  <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      // ack is a single-clk pulse even though the slot lasts several clks.
      a_ack <= done_a;
      b_ack <= done_b;
      if (done_a && !we_q) a_rdata <= vd_in;
      if (done_b && !we_q) b_rdata <= vd_in;

      a_cnt    <= a_cnt_nxt;
      b_cnt    <= b_cnt_nxt;
      a_starve <= a_starve | (a_cnt_nxt >= MAX_W);
      b_starve <= b_starve | (b_cnt_nxt >= MAX_W);

      if (cen) begin
        ae  <= grant_a;
        be  <= grant_b;
        v_c <= !grant;
        voe <= grant && !we_sel;
        vwe <= grant &&  we_sel;
        // va/vd_out hold their last values outside CPU slots.
        if (grant) begin
          va      <= addr_sel;
          vd_out  <= wdata_sel;
          we_q    <= we_sel;
          gnt_b_q <= pick_b;
          last_b  <= pick_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_tnkiii_vram_arbiter.sv
// Directed bench for tnkiii_vram_arbiter. Slot edges are produced by pulsing
// cen for one clk; outputs are sampled on the falling edge.
module tb_tnkiii_vram_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset, cen, vid_slot;
  logic          a_req, b_req, a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata, vd_in;
  logic          a_ack, b_ack, a_wait, b_wait, ae, be, v_c, voe, vwe;
  logic          a_starve, b_starve;
  logic [DW-1:0] a_rdata, b_rdata, vd_out;
  logic [AW-1:0] va;

  int n_checks = 0;
  int n_errors = 0;
  int a_acks = 0;
  int b_acks = 0;
  bit running = 1'b0;

  tnkiii_vram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset), .cen(cen), .vid_slot(vid_slot),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .vd_in(vd_in), .a_ack(a_ack), .b_ack(b_ack),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .a_wait(a_wait), .b_wait(b_wait),
    .ae(ae), .be(be), .v_c(v_c), .va(va), .vd_out(vd_out),
    .voe(voe), .vwe(vwe), .a_starve(a_starve), .b_starve(b_starve)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (a_ack) a_acks <= a_acks + 1;
    if (b_ack) b_acks <= b_acks + 1;
  end

  always @(negedge clk)
    if (running) check("ae_be_exclusive", {31'd0, ae & be}, 32'd0);

  // One slot edge; returns on the falling edge right after it.
  task automatic slot();
    @(negedge clk); cen = 1'b1;
    @(posedge clk);
    @(negedge clk); cen = 1'b0;
  endtask

  // One clk without a slot edge.
  task automatic step();
    @(negedge clk); cen = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; cen = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cen = 1'b0; vid_slot = 1'b0;
    a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0; vd_in = '0;
    do_reset();
    running = 1'b1;

    // Reset state
    check("rst_ae", ae, 0);       check("rst_be", be, 0);
    check("rst_v_c", v_c, 1);     check("rst_voe", voe, 0);
    check("rst_vwe", vwe, 0);     check("rst_va", va, 0);
    check("rst_vd_out", vd_out, 8'hFF);
    check("rst_a_ack", a_ack, 0); check("rst_b_ack", b_ack, 0);
    check("rst_a_rdata", a_rdata, 8'hFF);
    check("rst_b_rdata", b_rdata, 8'hFF);
    check("rst_a_starve", a_starve, 0);

    // Single read by A
    a_req = 1; a_we = 0; a_addr = 13'h0123;
    step();
    check("rd_a_wait", a_wait, 1);
    slot();
    check("rd_ae", ae, 1); check("rd_va", va, 13'h0123);
    check("rd_voe", voe, 1); check("rd_vwe", vwe, 0); check("rd_v_c", v_c, 0);
    check("rd_ack_early", a_ack, 0);
    vd_in = 8'h5A;
    step();
    check("rd_ae_hold", ae, 1); check("rd_voe_hold", voe, 1);
    slot();
    check("rd_ack", a_ack, 1); check("rd_rdata", a_rdata, 8'h5A);
    check("rd_wait_clear", a_wait, 0);
    check("rd_ae_off", ae, 0); check("rd_v_c_back", v_c, 1);
    check("rd_voe_off", voe, 0); check("rd_va_hold", va, 13'h0123);
    a_req = 0;
    step();
    check("rd_ack_pulse", a_ack, 0);

    // Simultaneous A and B from reset
    do_reset();
    a_acks = 0; b_acks = 0;
    a_req = 1; a_addr = 13'h0010; b_req = 1; b_we = 0; b_addr = 13'h0020;
    vd_in = 8'h11;
    slot();
    check("tie_ae", ae, 1); check("tie_be", be, 0); check("tie_va", va, 13'h0010);
    check("tie_b_wait", b_wait, 1);
    slot();
    check("tie_a_ack", a_ack, 1); check("tie_a_rdata", a_rdata, 8'h11);
    check("tie_be2", be, 1); check("tie_ae2", ae, 0); check("tie_va2", va, 13'h0020);
    a_req = 0; vd_in = 8'h22;
    slot();
    check("tie_b_ack", b_ack, 1); check("tie_b_rdata", b_rdata, 8'h22);
    check("tie_be3", be, 0);
    b_req = 0;
    slot(); slot();
    check("tie_a_count", a_acks, 1); check("tie_b_count", b_acks, 1);

    // B write while video slot request rises mid-slot
    b_req = 1; b_we = 1; b_addr = 13'h1FFF; b_wdata = 8'h7F;
    slot();
    check("wr_be", be, 1); check("wr_vwe", vwe, 1); check("wr_voe", voe, 0);
    check("wr_va", va, 13'h1FFF); check("wr_vd_out", vd_out, 8'h7F);
    vid_slot = 1;
    step();
    check("wr_vwe_hold", vwe, 1); check("wr_v_c_hold", v_c, 0);
    slot();
    check("wr_b_ack", b_ack, 1); check("wr_b_rdata_kept", b_rdata, 8'h22);
    check("wr_video_v_c", v_c, 1); check("wr_vwe_off", vwe, 0); check("wr_be_off", be, 0);
    check("wr_vd_out_hold", vd_out, 8'h7F);
    b_req = 0; b_we = 0;
    slot();
    check("wr_video_stay", v_c, 1);
    vid_slot = 0;

    // Starvation under continuous video
    do_reset();
    vid_slot = 1; a_req = 1; a_we = 0; a_addr = 13'h0456;
    for (int i = 1; i <= 14; i++) slot();
    check("stv_not_yet", a_starve, 0);
    slot();
    check("stv_set", a_starve, 1);
    slot();
    check("stv_no_grant", ae, 0);
    vid_slot = 0;
    slot();
    check("stv_grant", ae, 1); check("stv_va", va, 13'h0456);
    vd_in = 8'h33;
    slot();
    check("stv_ack", a_ack, 1); check("stv_rdata", a_rdata, 8'h33);
    a_req = 0;
    slot();
    check("stv_sticky", a_starve, 1);

    // Reset during an access
    do_reset();
    a_req = 1; a_addr = 13'h00AB; vd_in = 8'h44;
    slot();
    check("ra_ae", ae, 1);
    @(negedge clk); reset = 1'b1; cen = 1'b1;
    @(negedge clk); reset = 1'b0; cen = 1'b0;
    check("ra_ae_rst", ae, 0); check("ra_v_c", v_c, 1); check("ra_va", va, 0);
    check("ra_vd_out", vd_out, 8'hFF); check("ra_ack", a_ack, 0);
    check("ra_rdata", a_rdata, 8'hFF); check("ra_voe", voe, 0);
    slot();
    check("ra_regrant", ae, 1); check("ra_va2", va, 13'h00AB);
    slot();
    check("ra_ack2", a_ack, 1); check("ra_rdata2", a_rdata, 8'h44);
    a_req = 0;
    step();

    running = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tnkiii_vram_arbiter.md
TNKIII_VRAM_ARBITER -- requirements
Module: tnkiii_vram_arbiter

Interface
REQ-001 Parameter AW, default 13, shared video address bus width (VA).
REQ-002 Parameter DW, default 8, shared video data bus width (VD).
REQ-003 Parameter MAX_WAIT, default 15, starvation threshold in slots; counters 4 bits, saturating.
REQ-004 clk  in  1  system clock (53.6 MHz); one clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cen  in  1  slot strobe (3.35 MHz clock enable); all arbitration decisions are taken only on clk edges with cen=1 ("slot edges").
REQ-007 vid_slot  in  1  video fetch owns the bus in the coming slot; sampled on slot edges.
REQ-008 a_req, b_req  in  1 each  CPU A / CPU B access request; held high until the matching ack.
REQ-009 a_we, b_we  in  1 each  1=write, 0=read.
REQ-010 a_addr, b_addr  in  AW each  request address.
REQ-011 a_wdata, b_wdata  in  DW each  write data.
REQ-012 vd_in  in  DW  read data returned from the shared VRAMs.
REQ-013 a_ack, b_ack  out  1 each  one-clk completion pulse.
REQ-014 a_rdata, b_rdata  out  DW each  read data registered at completion, held until next read completion.
REQ-015 a_wait, b_wait  out  1 each  = req AND NOT ack (combinational CPU stall).
REQ-016 ae, be  out  1 each  CPU A / CPU B owns the bus (one-hot or both 0).
REQ-017 v_c  out  1  1=video owns SRAM address mux, 0=CPU access.
REQ-018 va  out  AW; vd_out  out  DW; voe, vwe  out  1 each  shared bus drive.
REQ-019 a_starve, b_starve  out  1 each  sticky starvation flags.

Function
REQ-020 FSM states IDLE, VIDEO, CPU_ACC; state changes only on slot edges.
REQ-021 At a slot edge in CPU_ACC, the access completes: the granted side's ack pulses for exactly that one clk; on a read, vd_in is captured into that side's rdata on the same edge.
REQ-022 Next-state selection at every slot edge, after completion: vid_slot=1 -> VIDEO; else any eligible request -> CPU_ACC; else IDLE.
REQ-023 A requester being acked on that edge is ineligible on that edge (no double service).
REQ-024 Both requesters eligible: grant the one not granted last (round robin); last-grant pointer resets to B, so A wins the first tie.
REQ-025 On grant: latch addr, we and wdata; set ae or be; va, vd_out, voe and vwe stay stable for the entire CPU_ACC slot.
REQ-026 In CPU_ACC: v_c=0; voe=~we_latched; vwe=we_latched. In IDLE or VIDEO: v_c=1, voe=0, vwe=0, ae=be=0; va and vd_out hold their last values.
REQ-027 An access in progress is never aborted; vid_slot=1 during CPU_ACC takes effect only at the completing slot edge.
REQ-028 Starvation counter per side: increments on each slot edge where req=1 and that side is not granted; clears on grant; saturates at 15.
REQ-029 starve flag sets when its counter reaches MAX_WAIT and stays set until reset.
REQ-030 A request dropped before grant is ignored, with no ack; its counter clears.
REQ-031 With cen=0, all registered outputs hold, except ack, which returns to 0 one clk after its pulse.

Reset
REQ-032 reset=1 at a clk edge forces, regardless of cen: state IDLE; ae=be=0; v_c=1; voe=vwe=0; va=0; vd_out=all ones; a_ack=b_ack=0; a_rdata=b_rdata=all ones; counters 0; starve flags 0; last-grant=B.
REQ-033 Reset during CPU_ACC aborts the access: no ack and no rdata update.

Verification
REQ-034 A reads addr 0x0123, vid_slot=0, vd_in=0x5A -> ae=1, va=0x0123, voe=1 for one slot; a_ack one clk at next slot edge; a_rdata=0x5A.
REQ-035 A and B request simultaneously from reset -> A granted first, B in the next slot; each ack exactly once; ae/be never both 1.
REQ-036 B write 0x7F to 0x1FFF while vid_slot rises mid-slot -> write completes (vwe=1 for full slot, b_ack pulses), then VIDEO with v_c=1.
REQ-037 vid_slot held 1 for 16 slots with a_req=1 -> no grant; a_starve sets at the slot edge where the count reaches 15; grant follows when vid_slot=0.
REQ-038 Reset asserted mid-CPU_ACC -> all outputs at REQ-032 values next clk; no ack; a fresh request afterward is served normally.
